// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer: FSM states, mode
// identifiers and the rotation-order lookup used by auto mode.
package led_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SWITCH   = 3'd1,
    RUN_MAN  = 3'd2,
    RUN_AUTO = 3'd3,
    PAUSE    = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  localparam logic [3:0] MASK_FALLBACK = 4'b0001;

  // Nearest enabled mode strictly above current, wrapping 3 -> 0; returns
  // current when it is the only enabled mode. An empty mask means mode 0 only.
  function automatic logic [1:0] next_enabled_mode(input logic [1:0] current,
                                                   input logic [3:0] mask);
    logic [3:0] eff;
    logic [1:0] cand;
    logic [1:0] pick;
    eff  = (mask == 4'b0000) ? MASK_FALLBACK : mask;
    pick = current;
    for (int i = 3; i >= 1; i--) begin
      cand = current + 2'(i);
      if (eff[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: free-running counter that emits a one-cycle tick every
// 2^(BASE_SHIFT + 2*speed_sel) cycles while run is high.
module led_step_prescaler #(
  parameter int BASE_SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed_sel,
  input  logic       run,
  input  logic       clear,
  output logic       step_tick
);

  localparam int CW = BASE_SHIFT + 7;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] period_m1;

  // The >= compare lets a rate increase take effect at once instead of
  // running the old, longer period out to its wrap point.
  always_comb begin
    period_m1 = (CW'(1) << (BASE_SHIFT + 2 * int'(speed_sel))) - CW'(1);
    step_tick = run && !clear && (cnt_q >= period_m1);
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (step_tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode and timing controller for the LED pattern generator: manual mode or
// auto rotation with per-mode dwell, step strobe and restart (clear) strobe.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int         BASE_SHIFT  = 4,
  parameter int         DWELL_STEPS = 32,
  parameter logic [3:0] MODE_MASK   = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       auto_en,
  input  logic [1:0] manual_mode,
  input  logic [1:0] speed_sel,
  input  logic       next_req,
  output logic [1:0] pattern_mode,
  output logic       step_tick,
  output logic       pattern_clear,
  output logic       auto_active
);

  seq_state_e state_q, state_d;
  seq_state_e resume_q, resume_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] dwell_q, dwell_d;
  logic       pre_run;
  logic       pre_clear;
  logic       tick;
  logic       dwell_done;

  led_step_prescaler #(
    .BASE_SHIFT(BASE_SHIFT)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .speed_sel(speed_sel),
    .run      (pre_run),
    .clear    (pre_clear),
    .step_tick(tick)
  );

  assign dwell_done = tick && (dwell_q == 8'(DWELL_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      resume_q <= RUN_MAN;
      mode_q   <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
    end
  end

  // The target mode is loaded on entry to SWITCH, so the clear pulse and the
  // new mode reach the generator in the same cycle.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;

    if (state_q == SWITCH) begin
      dwell_d = '0;
    end else if ((state_q == RUN_AUTO) && tick) begin
      dwell_d = dwell_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = SWITCH;
          mode_d  = auto_en ? MODE_COUNT : manual_mode;
        end
      end
      SWITCH: begin
        if (!ena) begin
          state_d  = PAUSE;
          resume_d = auto_en ? RUN_AUTO : RUN_MAN;
        end else begin
          state_d = auto_en ? RUN_AUTO : RUN_MAN;
        end
      end
      RUN_MAN: begin
        if (!ena) begin
          state_d  = PAUSE;
          resume_d = RUN_MAN;
        end else if (auto_en) begin
          state_d = SWITCH;
          mode_d  = next_enabled_mode(mode_q - 2'd1, MODE_MASK);
        end else if (manual_mode != mode_q) begin
          state_d = SWITCH;
          mode_d  = manual_mode;
        end
      end
      RUN_AUTO: begin
        if (!ena) begin
          state_d  = PAUSE;
          resume_d = RUN_AUTO;
        end else if (!auto_en) begin
          state_d = SWITCH;
          mode_d  = manual_mode;
        end else if (next_req || dwell_done) begin
          state_d = SWITCH;
          mode_d  = next_enabled_mode(mode_q, MODE_MASK);
        end
      end
      PAUSE: begin
        if (ena) begin
          state_d = resume_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A skip request in auto mode consumes its cycle without emitting a step.
  always_comb begin
    pre_clear     = (state_q == SWITCH);
    pre_run       = ena && ((state_q == RUN_MAN) ||
                            ((state_q == RUN_AUTO) && !(auto_en && next_req)));
    pattern_clear = (state_q == SWITCH) && ena;
    auto_active   = (state_q == RUN_AUTO) || ((state_q == SWITCH) && auto_en);
    step_tick     = tick;
  end

  assign pattern_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: three instances (mode masks 1111, 1010,
// 0000) driven in parallel, each tracked cycle by cycle by a behavioural model.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       auto_en;
  logic [1:0] manual_mode;
  logic [1:0] speed_sel;
  logic       next_req;
  logic [1:0] pm [3];
  logic       tk [3];
  logic       cl [3];
  logic       aa [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ms_st   [3];
  bit ms_auto [3];
  int ms_mode [3];
  int ms_pc   [3];
  int ms_dw   [3];

  int clr_cyc_q[$];
  int tick_cyc_q[$];
  int m0_q[$];
  int m1_q[$];
  int m2_q[$];
  int n_clr;
  int n_tick;
  logic [1:0] last_pm0;
  logic       last_aa0;

  typedef struct {
    bit   ena;
    bit   auto_en;
    logic [1:0] man;
    logic [1:0] spd;
    bit   nreq;
    int   n;
    int   e_mode;
    int   e_clr;
    int   e_tick;
    bit   e_act;
  } vec_t;

  vec_t vecs [12];

  led_pattern_sequencer #(.BASE_SHIFT(4), .DWELL_STEPS(32), .MODE_MASK(4'b1111)) dut0 (
    .clk(clk), .reset(reset), .ena(ena), .auto_en(auto_en), .manual_mode(manual_mode),
    .speed_sel(speed_sel), .next_req(next_req), .pattern_mode(pm[0]), .step_tick(tk[0]),
    .pattern_clear(cl[0]), .auto_active(aa[0]));

  led_pattern_sequencer #(.BASE_SHIFT(4), .DWELL_STEPS(32), .MODE_MASK(4'b1010)) dut1 (
    .clk(clk), .reset(reset), .ena(ena), .auto_en(auto_en), .manual_mode(manual_mode),
    .speed_sel(speed_sel), .next_req(next_req), .pattern_mode(pm[1]), .step_tick(tk[1]),
    .pattern_clear(cl[1]), .auto_active(aa[1]));

  led_pattern_sequencer #(.BASE_SHIFT(4), .DWELL_STEPS(32), .MODE_MASK(4'b0000)) dut2 (
    .clk(clk), .reset(reset), .ena(ena), .auto_en(auto_en), .manual_mode(manual_mode),
    .speed_sel(speed_sel), .next_req(next_req), .pattern_mode(pm[2]), .step_tick(tk[2]),
    .pattern_clear(cl[2]), .auto_active(aa[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] mask_of(int k);
    case (k)
      0: return 4'b1111;
      1: return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  // Mode rotation from the rules: scan upward (mod 4) for an enabled mode.
  function automatic int nextm(int mode, logic [3:0] mask, bit incl);
    logic [3:0] eff;
    int lo;
    int hi;
    eff = (mask == 4'b0000) ? 4'b0001 : mask;
    lo  = incl ? 0 : 1;
    hi  = incl ? 3 : 4;
    for (int d = lo; d <= hi; d++) begin
      if (eff[(mode + d) % 4]) return (mode + d) % 4;
    end
    return mode;
  endfunction

  function automatic bit m_tick(int k);
    int per;
    per = 1 << (4 + 2 * int'(speed_sel));
    return (ms_st[k] == 2) && ena && (ms_pc[k] >= per - 1) &&
           !(ms_auto[k] && auto_en && next_req);
  endfunction

  function automatic bit m_clear(int k);
    return (ms_st[k] == 1) && ena;
  endfunction

  function automatic bit m_active(int k);
    return ((ms_st[k] == 2) && ms_auto[k]) || ((ms_st[k] == 1) && auto_en);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms_st[k] = 0; ms_auto[k] = 0; ms_mode[k] = 0; ms_pc[k] = 0; ms_dw[k] = 0;
    end
  endtask

  // Model phases: 0 not started, 1 switching, 2 running, 3 paused.
  task automatic model_step(int k);
    bit t;
    bit expire;
    t = m_tick(k);
    case (ms_st[k])
      0: if (ena) begin
        ms_st[k] = 1;
        ms_mode[k] = auto_en ? 0 : int'(manual_mode);
      end
      1: begin
        ms_pc[k] = 0; ms_dw[k] = 0; ms_auto[k] = auto_en;
        ms_st[k] = ena ? 2 : 3;
      end
      2: if (!ena) begin
        ms_st[k] = 3;
      end else begin
        expire = ms_auto[k] && t && (ms_dw[k] == 31);
        ms_pc[k] = t ? 0 : ms_pc[k] + 1;
        if (ms_auto[k] && t) ms_dw[k] = ms_dw[k] + 1;
        if (auto_en != ms_auto[k]) begin
          ms_st[k] = 1;
          ms_mode[k] = auto_en ? nextm(ms_mode[k], mask_of(k), 1'b1) : int'(manual_mode);
        end else if (!ms_auto[k] && (int'(manual_mode) != ms_mode[k])) begin
          ms_st[k] = 1;
          ms_mode[k] = int'(manual_mode);
        end else if (ms_auto[k] && (next_req || expire)) begin
          ms_st[k] = 1;
          ms_mode[k] = nextm(ms_mode[k], mask_of(k), 1'b0);
        end
      end
      default: if (ena) ms_st[k] = 2;
    endcase
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic clear_records();
    clr_cyc_q.delete(); tick_cyc_q.delete();
    m0_q.delete(); m1_q.delete(); m2_q.delete();
  endtask

  // Inputs are stable when this is called; sample at negedge, advance at posedge.
  task automatic do_cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [4:0] ev;
      logic [4:0] gv;
      ev = {2'(ms_mode[k]), m_tick(k), m_clear(k), m_active(k)};
      gv = {pm[k], tk[k], cl[k], aa[k]};
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL lockstep dut%0d cyc %0d: got mode/tick/clr/act %b expected %b", k, cyc, gv, ev);
      end
    end
    if (cl[0]) begin clr_cyc_q.push_back(cyc); m0_q.push_back(int'(pm[0])); n_clr++; end
    if (cl[1]) m1_q.push_back(int'(pm[1]));
    if (cl[2]) m2_q.push_back(int'(pm[2]));
    if (tk[0]) begin tick_cyc_q.push_back(cyc); n_tick++; end
    last_pm0 = pm[0];
    last_aa0 = aa[0];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ena = 1'b0; auto_en = 1'b0; manual_mode = 2'd0; speed_sel = 2'd0; next_req = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_mode%0d", k), int'(pm[k]), 0);
      chk($sformatf("reset_out%0d", k), int'({tk[k], cl[k], aa[k]}), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    clear_records();
  endtask

  function automatic vec_t mkv(bit e, bit a, int m, int s, bit nr, int n,
                               int em, int ec, int et, bit ea);
    vec_t v;
    v.ena = e; v.auto_en = a; v.man = 2'(m); v.spd = 2'(s); v.nreq = nr; v.n = n;
    v.e_mode = em; v.e_clr = ec; v.e_tick = et; v.e_act = ea;
    return v;
  endfunction

  initial begin
    //            ena aut man spd nrq   n  mode clr tick act
    vecs[0]  = mkv(0, 0, 2, 0, 0,   5,  0,  0,  0, 0);
    vecs[1]  = mkv(1, 0, 2, 0, 0,   1,  0,  0,  0, 0);
    vecs[2]  = mkv(1, 0, 2, 0, 0,  17,  2,  1,  1, 0);
    vecs[3]  = mkv(1, 0, 2, 0, 0,  32,  2,  0,  2, 0);
    vecs[4]  = mkv(1, 0, 2, 1, 0,  10,  2,  0,  0, 0);
    vecs[5]  = mkv(0, 0, 2, 1, 0, 100,  2,  0,  0, 0);
    vecs[6]  = mkv(1, 0, 2, 1, 0,  55,  2,  0,  1, 0);
    vecs[7]  = mkv(1, 0, 1, 0, 0,   2,  1,  1,  0, 0);
    vecs[8]  = mkv(1, 0, 1, 0, 0,  16,  1,  0,  1, 0);
    vecs[9]  = mkv(1, 0, 1, 0, 1,   1,  1,  0,  0, 0);
    vecs[10] = mkv(1, 1, 1, 0, 0,   2,  1,  1,  0, 1);
    vecs[11] = mkv(1, 1, 1, 0, 0,  16,  1,  0,  1, 1);

    // Manual mode, pause/resume and manual->auto handover.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      ena = vecs[i].ena; auto_en = vecs[i].auto_en; manual_mode = vecs[i].man;
      speed_sel = vecs[i].spd; next_req = vecs[i].nreq;
      n_clr = 0; n_tick = 0;
      for (int c = 0; c < vecs[i].n; c++) do_cycle();
      chk($sformatf("vec%0d_mode", i), int'(last_pm0), vecs[i].e_mode);
      chk($sformatf("vec%0d_clears", i), n_clr, vecs[i].e_clr);
      chk($sformatf("vec%0d_ticks", i), n_tick, vecs[i].e_tick);
      chk($sformatf("vec%0d_active", i), int'(last_aa0), int'(vecs[i].e_act));
    end

    // Auto rotation: clears every 513 cycles, mode order per mask.
    apply_reset();
    ena = 1'b1; auto_en = 1'b1;
    for (int c = 0; c < 2060; c++) do_cycle();
    chk("auto_clear_count", clr_cyc_q.size(), 5);
    chk("auto_first_clear", (clr_cyc_q.size() > 0) ? clr_cyc_q[0] : -1, 1);
    for (int i = 1; i < 5; i++) begin
      if (i < clr_cyc_q.size())
        chk($sformatf("auto_spacing%0d", i), clr_cyc_q[i] - clr_cyc_q[i-1], 513);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < m0_q.size()) chk($sformatf("mask1111_mode%0d", i), m0_q[i], i % 4);
      if (i < m1_q.size()) chk($sformatf("mask1010_mode%0d", i), m1_q[i], (i == 0) ? 0 : ((i % 2 == 1) ? 1 : 3));
      if (i < m2_q.size()) chk($sformatf("mask0000_mode%0d", i), m2_q[i], 0);
    end
    chk("mask1010_clear_count", m1_q.size(), 5);
    chk("mask0000_clear_count", m2_q.size(), 5);

    // next_req after five dwell ticks.
    apply_reset();
    ena = 1'b1; auto_en = 1'b1;
    for (int c = 0; c < 85; c++) do_cycle();
    chk("nreq_ticks_before", tick_cyc_q.size(), 5);
    next_req = 1'b1;
    do_cycle();
    next_req = 1'b0;
    for (int c = 0; c < 514; c++) do_cycle();
    chk("nreq_clear_count", clr_cyc_q.size(), 3);
    chk("nreq_switch_cycle", (clr_cyc_q.size() > 1) ? clr_cyc_q[1] : -1, 86);
    chk("nreq_new_mode", (m0_q.size() > 1) ? m0_q[1] : -1, 1);
    chk("nreq_dwell_restart", (clr_cyc_q.size() > 2) ? clr_cyc_q[2] - clr_cyc_q[1] : -1, 513);
    chk("nreq_first_tick_after", (tick_cyc_q.size() > 5) ? tick_cyc_q[5] : -1, 102);

    // Rate increase mid-period fires immediately.
    apply_reset();
    ena = 1'b1; manual_mode = 2'd0; speed_sel = 2'd3;
    for (int c = 0; c < 502; c++) do_cycle();
    chk("speed_no_tick_yet", tick_cyc_q.size(), 0);
    speed_sel = 2'd0;
    for (int c = 0; c < 17; c++) do_cycle();
    chk("speed_tick_count", tick_cyc_q.size(), 2);
    chk("speed_fast_tick", (tick_cyc_q.size() > 0) ? tick_cyc_q[0] : -1, 502);
    chk("speed_next_tick", (tick_cyc_q.size() > 1) ? tick_cyc_q[1] : -1, 518);

    // Randomized run against the model.
    apply_reset();
    ena = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      ena = ($urandom_range(0, 99) < 93);
      if ($urandom_range(0, 249) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 149) == 0) manual_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) speed_sel = 2'($urandom_range(0, 3) == 3 ? 1 : 0);
      next_req = ($urandom_range(0, 59) == 0);
      do_cycle();
    end

    // Asynchronous reset in the middle of a cycle.
    ena = 1'b1; auto_en = 1'b0; manual_mode = 2'd3; next_req = 1'b0; speed_sel = 2'd0;
    for (int c = 0; c < 6; c++) do_cycle();
    chk("pre_reset_mode", int'(pm[0]), 3);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_reset_mode%0d", k), int'(pm[k]), 0);
      chk($sformatf("async_reset_out%0d", k), int'({tk[k], cl[k], aa[k]}), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ena = 1'b0;
    for (int c = 0; c < 3; c++) do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
